// File: rtl/cond_wait_loader_pkg.sv
// cond_wait_pkg: shared state encoding and default constants for the
// conditional wait-and-load block and its hold-off timer.
package cond_wait_pkg;

  localparam int CWL_WIDTH = 4;
  localparam int CWL_HOLD  = 1;
  localparam int CWL_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } cwl_state_e;

  // Timer width able to hold HOLD-1; never narrower than one bit.
  function automatic int cwl_timer_w(input int hold);
    return (hold > 1) ? $clog2(hold) : 1;
  endfunction

endpackage

// File: rtl/cond_wait_loader_if.sv
// Signal bundle between the stimulus/sequencer stage (master) and the
// wait-and-load block (slave).
interface cond_wait_loader_if
  import cond_wait_pkg::*;
#(
  parameter int WIDTH = CWL_WIDTH,
  parameter int CNT_W = CWL_CNT_W
);

  logic             enable;
  logic [WIDTH-1:0] value_in;
  logic [WIDTH-1:0] match_in;
  logic [WIDTH-1:0] load_in;
  logic [WIDTH-1:0] value_out;
  logic             load_pulse;
  logic             busy;
  logic [CNT_W-1:0] load_count;

  modport master (
    output enable, value_in, match_in, load_in,
    input  value_out, load_pulse, busy, load_count
  );

  modport slave (
    input  enable, value_in, match_in, load_in,
    output value_out, load_pulse, busy, load_count
  );

endinterface

// File: rtl/cond_wait_loader_hold_timer.sv
// cwl_hold_timer: hold-off down-counter. start loads HOLD-1, the count
// decrements to zero and expire is high whenever the count is zero.
// clear (and reset) force the count back to zero.
module cwl_hold_timer #(
  parameter int HOLD  = 1,
  parameter int CNT_W = 1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  input  logic i_clear,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] START_VAL = CNT_W'(HOLD - 1);

  logic [CNT_W-1:0] r_cnt;

  // Load on start, otherwise count down and park at zero.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_start) begin
      r_cnt <= START_VAL;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_expire = (r_cnt == '0);

endmodule

// File: rtl/cond_wait_loader.sv
// cond_wait_loader: every clock compares value_in against match_in while
// waiting; on a match loads load_in into value_out, strobes load_pulse and
// then holds off for HOLD cycles before comparing again. A persistent
// match therefore reloads every HOLD+1 cycles.
// Optional feature: define COND_WAIT_LOADER_CNT_EN to build the saturating
// load_count counter; otherwise load_count is tied to zero.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | disarmed; no compare, moves to ST_WAIT when enable is high
// ST_WAIT | compare every cycle; load on match
// ST_HOLD | hold-off after a load; inputs ignored until the timer expires
module cond_wait_loader
  import cond_wait_pkg::*;
#(
  parameter int WIDTH = CWL_WIDTH,
  parameter int HOLD  = CWL_HOLD,
  parameter int CNT_W = CWL_CNT_W
) (
  input logic               clk,
  input logic               reset,
  cond_wait_loader_if.slave bus
);

  localparam int TIMER_W = cwl_timer_w(HOLD);

  cwl_state_e       r_state;
  logic [WIDTH-1:0] r_value_out;
  logic             r_load_pulse;
  logic             r_busy;

  logic w_match;
  logic w_take;
  logic w_clear;
  logic w_expire;

  assign w_match = (bus.value_in == bus.match_in);
  // enable has priority over a simultaneous match
  assign w_take  = (r_state == ST_WAIT) && bus.enable && w_match;
  assign w_clear = !bus.enable;

  generate
    if (HOLD > 0) begin : g_timer
      cwl_hold_timer #(
        .HOLD  (HOLD),
        .CNT_W (TIMER_W)
      ) u_hold_timer (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_start  (w_take),
        .i_clear  (w_clear),
        .o_expire (w_expire)
      );
    end else begin : g_no_timer
      assign w_expire = 1'b1;
    end
  endgenerate

  // Sequencing FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_value_out  <= '0;
      r_load_pulse <= 1'b0;
      r_busy       <= 1'b0;
    end else if (!bus.enable) begin
      r_state      <= ST_IDLE;
      r_load_pulse <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_state      <= ST_WAIT;
          r_load_pulse <= 1'b0;
          r_busy       <= 1'b0;
        end
        ST_WAIT: begin
          if (w_match) begin
            r_value_out  <= bus.load_in;
            r_load_pulse <= 1'b1;
            if (HOLD > 0) begin
              r_state <= ST_HOLD;
              r_busy  <= 1'b1;
            end else begin
              r_state <= ST_WAIT;
              r_busy  <= 1'b0;
            end
          end else begin
            r_load_pulse <= 1'b0;
            r_busy       <= 1'b0;
          end
        end
        ST_HOLD: begin
          r_load_pulse <= 1'b0;
          if (w_expire) begin
            r_state <= ST_WAIT;
            r_busy  <= 1'b0;
          end else begin
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_load_pulse <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.value_out  = r_value_out;
  assign bus.load_pulse = r_load_pulse;
  assign bus.busy       = r_busy;

`ifdef COND_WAIT_LOADER_CNT_EN
  logic [CNT_W-1:0] r_load_count;

  // Saturating count of loads since reset, updated on the load edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_load_count <= '0;
    end else if (w_take && (r_load_count != '1)) begin
      r_load_count <= r_load_count + CNT_W'(1);
    end
  end

  assign bus.load_count = r_load_count;
`else
  assign bus.load_count = '0;
`endif

endmodule

// File: tb/tb_cond_wait_loader.sv
// Testbench for cond_wait_loader: table of directed vectors on a HOLD=1
// instance, then hand sequences for counter saturation and a HOLD=0
// instance.
module tb_cond_wait_loader;
  import cond_wait_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cond_wait_loader_if #(.WIDTH(4), .CNT_W(8)) bus_a ();
  cond_wait_loader_if #(.WIDTH(4), .CNT_W(8)) bus_b ();

  cond_wait_loader #(.WIDTH(4), .HOLD(1), .CNT_W(8)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  cond_wait_loader #(.WIDTH(4), .HOLD(0), .CNT_W(8)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] val;
    logic [3:0] mat;
    logic [3:0] ld;
    logic [3:0] vo;
    logic       lp;
    logic       bsy;
    int         loads;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int exp_cnt(input int n);
`ifdef COND_WAIT_LOADER_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, input logic en, input logic [3:0] val,
                     input logic [3:0] mat, input logic [3:0] ld, input logic [3:0] vo,
                     input logic lp, input logic bsy, input int loads);
    vec_t v;
    v.rst = rst; v.en = en; v.val = val; v.mat = mat; v.ld = ld;
    v.vo = vo; v.lp = lp; v.bsy = bsy; v.loads = loads;
    vecs.push_back(v);
  endtask

  initial begin
    reset          = 1'b1;
    bus_a.enable   = 1'b0;
    bus_a.value_in = '0;
    bus_a.match_in = '0;
    bus_a.load_in  = '0;
    bus_b.enable   = 1'b0;
    bus_b.value_in = '0;
    bus_b.match_in = 4'd7;
    bus_b.load_in  = 4'd10;

    // rst en val mat ld | value_out pulse busy loads
    add(1, 1, 3, 3, 3,   0, 0, 0, 0);
    add(1, 1, 3, 3, 3,   0, 0, 0, 0);
    add(0, 1, 3, 3, 3,   0, 0, 0, 0);   // IDLE -> WAIT
    add(0, 1, 3, 3, 3,   3, 1, 1, 1);   // first load 2 edges after release
    add(1, 1, 0, 3, 3,   0, 0, 0, 0);   // reset mid-HOLD
    add(0, 1, 0, 3, 3,   0, 0, 0, 0);
    add(0, 1, 0, 3, 3,   0, 0, 0, 0);
    add(0, 1, 1, 3, 3,   0, 0, 0, 0);
    add(0, 1, 1, 3, 3,   0, 0, 0, 0);
    add(0, 1, 2, 3, 3,   0, 0, 0, 0);
    add(0, 1, 2, 3, 3,   0, 0, 0, 0);
    add(0, 1, 3, 3, 3,   3, 1, 1, 1);
    add(0, 1, 0, 3, 3,   3, 0, 0, 1);
    add(0, 1, 0, 3, 3,   3, 0, 0, 1);
    for (int k = 0; k < 6; k++) begin   // persistent match: load every 2 cycles
      add(0, 1, 3, 3, 9, 9, 1, 1, 2 + k);
      add(0, 1, 3, 3, 9, 9, 0, 0, 2 + k);
    end
    add(0, 1, 3, 3, 9,   9, 1, 1, 8);
    add(0, 1, 3, 3, 4,   9, 0, 0, 8);   // inputs ignored during HOLD
    add(0, 0, 3, 3, 6,   9, 0, 0, 8);   // enable falls with match: no load
    add(0, 1, 3, 3, 6,   9, 0, 0, 8);   // IDLE -> WAIT, no compare
    add(0, 1, 3, 3, 6,   6, 1, 1, 9);
    add(0, 0, 3, 3, 6,   6, 0, 0, 9);   // enable drop mid-HOLD, value kept
    add(0, 0, 3, 3, 6,   6, 0, 0, 9);
    add(0, 1, 5, 5, 12,  6, 0, 0, 9);
    add(0, 1, 5, 5, 12, 12, 1, 1, 10);
    add(1, 1, 5, 5, 12,  0, 0, 0, 0);   // reset mid-HOLD
    add(0, 0, 5, 5, 12,  0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      reset          = vecs[i].rst;
      bus_a.enable   = vecs[i].en;
      bus_a.value_in = vecs[i].val;
      bus_a.match_in = vecs[i].mat;
      bus_a.load_in  = vecs[i].ld;
      @(posedge clk); #1;
      check($sformatf("v%0d value_out", i), bus_a.value_out, vecs[i].vo);
      check($sformatf("v%0d load_pulse", i), bus_a.load_pulse, vecs[i].lp);
      check($sformatf("v%0d busy", i), bus_a.busy, vecs[i].bsy);
      check($sformatf("v%0d load_count", i), bus_a.load_count, exp_cnt(vecs[i].loads));
    end

    // Saturation: persistent match loads on every even edge after release.
    reset = 1'b1;
    @(posedge clk); #1;
    reset          = 1'b0;
    bus_a.enable   = 1'b1;
    bus_a.value_in = 4'd3;
    bus_a.match_in = 4'd3;
    bus_a.load_in  = 4'd7;
    for (int c = 1; c <= 520; c++) begin
      @(posedge clk); #1;
      if (c == 510) check("sat count at 255th load", bus_a.load_count, exp_cnt(255));
      if (c == 512) begin
        check("sat pulse on 256th load", bus_a.load_pulse, 1);
        check("sat count holds", bus_a.load_count, exp_cnt(256));
      end
    end
    check("sat count end", bus_a.load_count, exp_cnt(260));
    check("sat value_out", bus_a.value_out, 7);

    // HOLD=0 instance: persistent match gives a pulse every cycle.
    bus_a.enable   = 1'b0;
    reset          = 1'b1;
    bus_b.enable   = 1'b1;
    bus_b.value_in = 4'd0;
    @(posedge clk); #1;
    check("h0 reset value_out", bus_b.value_out, 0);
    check("h0 reset load_pulse", bus_b.load_pulse, 0);
    reset = 1'b0;
    @(posedge clk); #1;   // IDLE -> WAIT
    check("h0 wait load_pulse", bus_b.load_pulse, 0);
    bus_b.value_in = 4'd7;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("h0 c%0d value_out", k), bus_b.value_out, 10);
      check($sformatf("h0 c%0d load_pulse", k), bus_b.load_pulse, 1);
      check($sformatf("h0 c%0d busy", k), bus_b.busy, 0);
      check($sformatf("h0 c%0d load_count", k), bus_b.load_count, exp_cnt(k));
    end
    bus_b.value_in = 4'd0;
    @(posedge clk); #1;
    check("h0 after value_out", bus_b.value_out, 10);
    check("h0 after load_pulse", bus_b.load_pulse, 0);
    check("h0 after busy", bus_b.busy, 0);
    check("h0 after load_count", bus_b.load_count, exp_cnt(5));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
